// File: rtl/addsub_seq_pkg.sv
// Shared constants and types for the nibble-serial add/subtract sequencer.
package addsub_seq_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Operand/result bus of addsub_seq_ctrl: producer side (in_*) and consumer side (out_*).
// Valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// once valid is raised the sender holds valid and payload stable until that edge.
interface addsub_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLES * 4;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow
  );

endinterface

// File: rtl/addsub_nibble_slice.sv
// Combinational 4-bit ripple add slice; exposes the raw carry out and the carry into bit 3.
module addsub_nibble_slice
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c_msb
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign cout  = c[NIBBLE_W];
  assign c_msb = c[NIBBLE_W-1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit slice walked over NIBBLES cycles.
// Optional ADDSUB_SEQ_SATURATE_EN clamps the result to the signed range on overflow.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  addsub_seq_ctrl_if.slave   bus,
  output state_t             dbg_state_o
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

`ifdef ADDSUB_SEQ_SATURATE_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  logic [1:0]                            state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic                                  carry_q, carry_d;
  logic                                  op_q, op_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]      a_q, a_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]      b_q, b_d;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]      res_q, res_d;
  logic                                  cflag_q, cflag_d;
  logic                                  ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] sl_sum;
  logic                sl_cout;
  logic                sl_c_msb;

  addsub_nibble_slice u_slice (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .sum   (sl_sum),
    .cout  (sl_cout),
    .c_msb (sl_c_msb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cflag_d = cflag_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          // Subtract is A + ~B + 1: invert B once here and seed the chain carry with op.
          a_d     = bus.a;
          b_d     = bus.b ^ {W{bus.op}};
          op_d    = bus.op;
          carry_d = bus.op;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[idx_q] = sl_sum;
        carry_d      = sl_cout;
        if (idx_q == IDX_LAST) begin
          // Borrow is the inverted raw carry; only the exported flag sees the inversion.
          cflag_d = sl_cout ^ (op_q == OP_SUB);
          ovf_d   = sl_cout ^ sl_c_msb;
`ifdef ADDSUB_SEQ_SATURATE_EN
          if (ovf_d) begin
            res_d = sl_sum[NIBBLE_W-1] ? SAT_MAX : SAT_MIN;
          end
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cflag_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cflag_q <= cflag_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.carry     = cflag_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state_o   = state_t'(state_q);

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl (NIBBLES=4): directed vector table, corner sequences, random ops.
module tb_addsub_seq_ctrl;
  import addsub_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = NIB * 4;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } vec_t;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     errors;
  logic [W+1:0] exp_q[$];

  addsub_seq_ctrl_if #(.NIBBLES(NIB)) ifc ();

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .dbg_state_o (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word two's complement arithmetic.
  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (!o) begin
      full = {1'b0, av} + {1'b0, bv};
      r    = full[W-1:0];
      c    = full[W];
      v    = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
    end else begin
      r = av - bv;
      c = (av < bv);
      v = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
    end
`ifdef ADDSUB_SEQ_SATURATE_EN
    if (v) r = r[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return {r, c, v};
  endfunction

  // Driver: one full transaction, with `hold` extra DONE cycles of out_ready=0.
  task automatic do_op(input logic o, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold,
                       output logic [W-1:0] r, output logic c, output logic v);
    int n;
    logic [W-1:0] r0;
    n = 0;
    while (ifc.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 32'(n < 20), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.op       = o;
    ifc.a        = av;
    ifc.b        = bv;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.a        = W'($urandom);
    ifc.b        = W'($urandom);
    ifc.op       = 1'($urandom_range(0, 1));
    n = 0;
    while (ifc.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'(NIB));
    r0 = ifc.result;
    for (int i = 0; i < hold; i++) begin
      ifc.in_valid = 1'($urandom_range(0, 1));
      ifc.a        = W'($urandom);
      ifc.b        = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", 32'(ifc.out_valid), 32'd1);
      check("hold_in_ready", 32'(ifc.in_ready), 32'd0);
      check("hold_result", 32'(ifc.result), 32'(r0));
    end
    ifc.in_valid = 1'b0;
    r = ifc.result;
    c = ifc.carry;
    v = ifc.overflow;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    check("out_valid_drop", 32'(ifc.out_valid), 32'd0);
    check("in_ready_back", 32'(ifc.in_ready), 32'd1);
  endtask

  initial begin
    vec_t         vecs[7];
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic [W+1:0] e;
    logic         ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks = 0;
    errors = 0;

    vecs[0] = '{op: OP_ADD, a: 16'h1234, b: 16'h0FFF, res: 16'h2233, c: 1'b0, v: 1'b0};
    vecs[1] = '{op: OP_ADD, a: 16'hFFFF, b: 16'h0001, res: 16'h0000, c: 1'b1, v: 1'b0};
    vecs[2] = '{op: OP_SUB, a: 16'h0005, b: 16'h0007, res: 16'hFFFE, c: 1'b1, v: 1'b0};
    vecs[5] = '{op: OP_SUB, a: 16'h0000, b: 16'h0000, res: 16'h0000, c: 1'b0, v: 1'b0};
`ifdef ADDSUB_SEQ_SATURATE_EN
    vecs[3] = '{op: OP_SUB, a: 16'h8000, b: 16'h0001, res: 16'h8000, c: 1'b0, v: 1'b1};
    vecs[4] = '{op: OP_ADD, a: 16'h7FFF, b: 16'h0001, res: 16'h7FFF, c: 1'b0, v: 1'b1};
    vecs[6] = '{op: OP_ADD, a: 16'h8000, b: 16'h8000, res: 16'h8000, c: 1'b1, v: 1'b1};
`else
    vecs[3] = '{op: OP_SUB, a: 16'h8000, b: 16'h0001, res: 16'h7FFF, c: 1'b0, v: 1'b1};
    vecs[4] = '{op: OP_ADD, a: 16'h7FFF, b: 16'h0001, res: 16'h8000, c: 1'b0, v: 1'b1};
    vecs[6] = '{op: OP_ADD, a: 16'h8000, b: 16'h8000, res: 16'h0000, c: 1'b1, v: 1'b1};
`endif

    // Reset
    ifc.in_valid  = 1'b1;
    ifc.op        = 1'b0;
    ifc.a         = 16'hAAAA;
    ifc.b         = 16'h5555;
    ifc.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_result", 32'(ifc.result), 32'd0);
    check("rst_carry", 32'(ifc.carry), 32'd0);
    check("rst_overflow", 32'(ifc.overflow), 32'd0);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, r, c, v);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].c));
      check($sformatf("vec%0d_overflow", i), 32'(v), 32'(vecs[i].v));
    end

    // Stall in DONE for 5 cycles with noise on the input side, then a fresh op
    do_op(OP_ADD, 16'h1234, 16'h0FFF, 5, r, c, v);
    check("stall_result", 32'(r), 32'h2233);
    check("stall_carry", 32'(c), 32'd0);
    do_op(OP_SUB, 16'h0005, 16'h0007, 0, r, c, v);
    check("after_stall_result", 32'(r), 32'hFFFE);
    check("after_stall_borrow", 32'(c), 32'd1);

    // Reset in the middle of RUN (idx == 2)
    ifc.in_valid = 1'b1;
    ifc.op       = OP_ADD;
    ifc.a        = 16'hFFFF;
    ifc.b        = 16'h0001;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_run_state", 32'(dbg_state), 32'(RUN));
    rst          = 1'b1;
    ifc.in_valid = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_result", 32'(ifc.result), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ignores_in_valid", 32'(dbg_state), 32'(IDLE));
    ifc.in_valid = 1'b0;
    rst          = 1'b0;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    do_op(OP_SUB, 16'h0010, 16'h0001, 0, r, c, v);
    check("post_rst_result", 32'(r), 32'h000F);
    check("post_rst_borrow", 32'(c), 32'd0);
    check("post_rst_overflow", 32'(v), 32'd0);

    // Random ops against the whole-word model
    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      exp_q.push_back(model(ro, ra, rb));
      do_op(ro, ra, rb, $urandom_range(0, 2), r, c, v);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_result", i), 32'(r), 32'(e[W+1:2]));
      check($sformatf("rand%0d_carry", i), 32'(c), 32'(e[1]));
      check($sformatf("rand%0d_overflow", i), 32'(v), 32'(e[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
